// File: rtl/fifo_wctrl_param.sv
// Write-side controller for an async FIFO: write pointer, read-pointer synchroniser,
// full / almost-full / free-space flags and a sticky overflow flag, all in the wclk domain.
module fifo_wctrl_param #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic                       wren,
  input  logic [$clog2(DEPTH):0]     rptr_gray,
  input  logic [$clog2(DEPTH):0]     afull_lvl,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH)-1:0]   waddr,
  output logic [$clog2(DEPTH):0]     wptr,
  output logic                       wen_ram,
  output logic                       wfull,
  output logic                       walmost_full,
  output logic [$clog2(DEPTH):0]     wfree,
  output logic                       wovf
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PW     = ADDR_W + 1;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rq_gray;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_next;

  // Read-pointer synchroniser; zero stages means the caller already synchronised it.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rq_gray = rptr_gray;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= rptr_gray;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign rq_gray = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign wen_ram    = wren & ~wfull;
  assign wbin_next  = wbin + PW'(wen_ram);
  assign wgray_next = b2g(wbin_next);
  assign rbin       = g2b(rq_gray);
  // Stale rbin only ever makes occupancy look higher, so the flags err on the safe side.
  assign lvl_next   = wbin_next - rbin;
  assign waddr      = wbin[ADDR_W-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wfree        <= PW'(DEPTH);
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]});
      walmost_full <= (lvl_next >= afull_lvl);
      wfree        <= PW'(DEPTH) - lvl_next;
      // A dropped write outranks a simultaneous clear.
      if (wren && wfull) begin
        wovf <= 1'b1;
      end else if (ovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wctrl_param.sv
// Scoreboard bench for fifo_wctrl_param: three instances (8/2, 16/3, 4/0) share one clock;
// stimulus queues cycle-tagged expectations and a negedge monitor compares them.
module tb_fifo_wctrl_param;

  localparam int F_WPTR = 0, F_WADDR = 1, F_WEN = 2, F_FULL = 3;
  localparam int F_AF = 4, F_FREE = 5, F_OVF = 6, F_HAM = 7;

  typedef struct {
    int          cyc;
    int          d;
    int          f;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic wrst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic       wren_in [3];
  logic [4:0] rptr_in [3];
  logic [4:0] lvl_in  [3];
  logic       clr_in  [3];

  logic [2:0] a_waddr; logic [3:0] a_wptr, a_wfree; logic a_wen, a_full, a_af, a_ovf;
  logic [3:0] b_waddr; logic [4:0] b_wptr, b_wfree; logic b_wen, b_full, b_af, b_ovf;
  logic [1:0] c_waddr; logic [2:0] c_wptr, c_wfree; logic c_wen, c_full, c_af, c_ovf;

  logic [31:0] act [3][7];
  logic [31:0] prev_wptr [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_wctrl_param #(.DEPTH(8), .SYNC_STAGES(2)) u_a (
    .wclk(clk), .wrst_n(wrst_n), .wren(wren_in[0]), .rptr_gray(rptr_in[0][3:0]),
    .afull_lvl(lvl_in[0][3:0]), .ovf_clr(clr_in[0]), .waddr(a_waddr), .wptr(a_wptr),
    .wen_ram(a_wen), .wfull(a_full), .walmost_full(a_af), .wfree(a_wfree), .wovf(a_ovf));

  fifo_wctrl_param #(.DEPTH(16), .SYNC_STAGES(3)) u_b (
    .wclk(clk), .wrst_n(wrst_n), .wren(wren_in[1]), .rptr_gray(rptr_in[1]),
    .afull_lvl(lvl_in[1]), .ovf_clr(clr_in[1]), .waddr(b_waddr), .wptr(b_wptr),
    .wen_ram(b_wen), .wfull(b_full), .walmost_full(b_af), .wfree(b_wfree), .wovf(b_ovf));

  fifo_wctrl_param #(.DEPTH(4), .SYNC_STAGES(0)) u_c (
    .wclk(clk), .wrst_n(wrst_n), .wren(wren_in[2]), .rptr_gray(rptr_in[2][2:0]),
    .afull_lvl(lvl_in[2][2:0]), .ovf_clr(clr_in[2]), .waddr(c_waddr), .wptr(c_wptr),
    .wen_ram(c_wen), .wfull(c_full), .walmost_full(c_af), .wfree(c_wfree), .wovf(c_ovf));

  always_comb begin
    act[0][F_WPTR] = 32'(a_wptr); act[0][F_WADDR] = 32'(a_waddr); act[0][F_WEN] = 32'(a_wen);
    act[0][F_FULL] = 32'(a_full); act[0][F_AF] = 32'(a_af); act[0][F_FREE] = 32'(a_wfree);
    act[0][F_OVF] = 32'(a_ovf);
    act[1][F_WPTR] = 32'(b_wptr); act[1][F_WADDR] = 32'(b_waddr); act[1][F_WEN] = 32'(b_wen);
    act[1][F_FULL] = 32'(b_full); act[1][F_AF] = 32'(b_af); act[1][F_FREE] = 32'(b_wfree);
    act[1][F_OVF] = 32'(b_ovf);
    act[2][F_WPTR] = 32'(c_wptr); act[2][F_WADDR] = 32'(c_waddr); act[2][F_WEN] = 32'(c_wen);
    act[2][F_FULL] = 32'(c_full); act[2][F_AF] = 32'(c_af); act[2][F_FREE] = 32'(c_wfree);
    act[2][F_OVF] = 32'(c_ovf);
  end

  function automatic logic [31:0] gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Queue an expectation dly edges from now, kept sorted by cycle.
  task automatic expect_at(input int d, input int f, input logic [31:0] v, input int dly,
                           input string name);
    exp_t e;
    int   idx;
    e.cyc = cyc + dly; e.d = d; e.f = f; e.val = v; e.name = name;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string name);
    expect_at(0, F_WPTR, 0, 0, {name, "_wptr"});
    expect_at(0, F_WADDR, 0, 0, {name, "_waddr"});
    expect_at(0, F_FULL, 0, 0, {name, "_wfull"});
    expect_at(0, F_AF, 0, 0, {name, "_afull"});
    expect_at(0, F_OVF, 0, 0, {name, "_wovf"});
    expect_at(0, F_FREE, 8, 0, {name, "_wfree"});
  endtask

  // Fill instance d to full, then move the read pointer by one and time the full release.
  task automatic full_latency(input int d, input int depth, input int sync, input logic af_exp);
    wren_in[d] = 1'b1;
    rptr_in[d] = '0;
    repeat (depth) tick();
    expect_at(d, F_FULL, 1, 0, "lat_full_set");
    expect_at(d, F_FREE, 0, 0, "lat_free0");
    expect_at(d, F_WPTR, gray(32'(depth)), 0, "lat_wptr");
    expect_at(d, F_AF, 32'(af_exp), 0, "lat_afull");
    wren_in[d] = 1'b0;
    rptr_in[d] = 5'(gray(1));
    for (int k = 1; k <= sync; k++) expect_at(d, F_FULL, 1, k, "lat_full_hold");
    expect_at(d, F_FULL, 0, sync + 1, "lat_full_clr");
    expect_at(d, F_FREE, 1, sync + 1, "lat_free1");
    repeat (sync + 1) tick();
  endtask

  exp_t        me;
  logic [31:0] mact;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      mact = (me.f == F_HAM) ? 32'($countones(act[me.d][F_WPTR] ^ prev_wptr[me.d]))
                             : act[me.d][me.f];
      checks++;
      if (me.cyc != cyc || mact !== me.val) begin
        failures++;
        $display("FAIL %s dut=%0d cyc=%0d: got %0h expected %0h (due cyc %0d)",
                 me.name, me.d, cyc, mact, me.val, me.cyc);
      end
    end
    for (int i = 0; i < 3; i++) prev_wptr[i] = act[i][F_WPTR];
  end

  logic [3:0] mw;
  initial begin
    for (int i = 0; i < 3; i++) begin
      wren_in[i] = 1'b0; rptr_in[i] = '0; clr_in[i] = 1'b0; prev_wptr[i] = '0;
    end
    lvl_in[0] = 5'd6; lvl_in[1] = 5'd0; lvl_in[2] = 5'd5;

    // Power-on reset, then a reset landing in the middle of a write burst.
    repeat (2) tick();
    expect_reset("por");
    wrst_n = 1'b1;
    tick();
    wren_in[0] = 1'b1;
    expect_at(0, F_WADDR, 0, 0, "first_waddr");
    expect_at(0, F_WEN, 1, 0, "first_wen");
    expect_at(0, F_WPTR, 32'b0001, 1, "first_wptr");
    expect_at(0, F_WADDR, 1, 1, "second_waddr");
    repeat (3) tick();
    wrst_n = 1'b0;
    expect_reset("midrst");
    tick();
    wren_in[0] = 1'b0;
    wrst_n = 1'b1;
    tick();

    // Fill to full with the reader parked at zero; almost-full trips at 6.
    wren_in[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_at(0, F_WADDR, 32'(i), 0, "fill_waddr");
      expect_at(0, F_WEN, 1, 0, "fill_wen");
      tick();
      expect_at(0, F_WPTR, gray(32'(i + 1)), 0, "fill_wptr");
      expect_at(0, F_FREE, 32'(7 - i), 0, "fill_wfree");
      expect_at(0, F_AF, 32'(i + 1 >= 6), 0, "fill_afull");
      expect_at(0, F_FULL, 32'(i == 7), 0, "fill_wfull");
    end
    expect_at(0, F_WPTR, 32'b1100, 0, "full_wptr");
    expect_at(0, F_WADDR, 0, 0, "full_waddr");
    expect_at(0, F_WEN, 0, 0, "full_wen_blocked");

    checks++;
    if (a_full !== 1'b1) begin
      failures++;
      $display("FAIL direct_full: got %0b expected 1", a_full);
    end
    checks++;
    if (a_wptr !== 4'b1100) begin
      failures++;
      $display("FAIL direct_full_wptr: got %0h expected c", a_wptr);
    end
    checks++;
    if (a_wfree !== 4'd0) begin
      failures++;
      $display("FAIL direct_full_wfree: got %0d expected 0", a_wfree);
    end

    // Overflow while full, clear, then clear colliding with a fresh overflow.
    tick();
    expect_at(0, F_OVF, 1, 0, "ovf_set");
    expect_at(0, F_WPTR, 32'b1100, 0, "ovf_wptr_hold1");
    tick();
    expect_at(0, F_WPTR, 32'b1100, 0, "ovf_wptr_hold2");
    expect_at(0, F_WADDR, 0, 0, "ovf_waddr_hold");
    wren_in[0] = 1'b0; clr_in[0] = 1'b1;
    expect_at(0, F_OVF, 0, 1, "ovf_clear");
    tick();
    wren_in[0] = 1'b1; clr_in[0] = 1'b1;
    expect_at(0, F_WEN, 0, 0, "ovf2_wen");
    expect_at(0, F_OVF, 1, 1, "ovf_set_beats_clr");
    tick();
    wren_in[0] = 1'b0; clr_in[0] = 1'b0;

    // Read pointer jumps to bin 3: full and free respond after the two sync flops plus one.
    rptr_in[0] = 5'b00010;
    expect_at(0, F_FULL, 1, 1, "rd_full_hold1");
    expect_at(0, F_FREE, 0, 1, "rd_free_hold1");
    expect_at(0, F_FULL, 1, 2, "rd_full_hold2");
    expect_at(0, F_AF, 1, 2, "rd_afull_hold");
    expect_at(0, F_FULL, 0, 3, "rd_full_clr");
    expect_at(0, F_FREE, 3, 3, "rd_free3");
    expect_at(0, F_AF, 0, 3, "rd_afull_clr");
    repeat (3) tick();

    checks++;
    if (a_full !== 1'b0) begin
      failures++;
      $display("FAIL direct_rd_full: got %0b expected 0", a_full);
    end
    checks++;
    if (a_wfree !== 4'd3) begin
      failures++;
      $display("FAIL direct_rd_wfree: got %0d expected 3", a_wfree);
    end

    // Reader tracks the writer across several wraps.
    mw = 4'd8;
    wren_in[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rptr_in[0] = 5'(gray(32'(mw)));
      expect_at(0, F_WADDR, 32'(mw[2:0]), 0, "track_waddr");
      tick();
      mw = mw + 4'd1;
      expect_at(0, F_WPTR, gray(32'(mw)), 0, "track_wptr");
      expect_at(0, F_HAM, 1, 0, "track_hamming");
      expect_at(0, F_FULL, 0, 0, "track_no_full");
    end
    wren_in[0] = 1'b0;
    tick();

    full_latency(1, 16, 3, 1'b1);
    full_latency(2, 4, 0, 1'b0);

    repeat (3) tick();
    while (sb.size() != 0) begin
      me = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s dut=%0d: never compared, expected %0h at cyc %0d",
               me.name, me.d, me.val, me.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
